// File: rtl/booth_mult4_pkg.sv
// Shared constants and helpers for the booth_mult4 sequential multiplier.
package booth_mult4_pkg;

    // FSM state encodings, kept as plain constants so older netlists and
    // lab top-levels that probe the state register stay compatible.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // Number of Booth iterations for a 4-bit multiplier.
    localparam int         ITER_COUNT = 4;
    localparam logic [2:0] CNT_LAST   = 3'(ITER_COUNT - 1);

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10
    } booth_op_e;

    // Radix-2 Booth recoding of the pair {Q[0], q_1}.
    function automatic booth_op_e booth_op(input logic q0, input logic q_1);
        case ({q0, q_1})
            2'b01:   return OP_ADD;
            2'b10:   return OP_SUB;
            default: return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/booth_mult4_if.sv
// Start/busy/done handshake bundle between a requester and booth_mult4.
interface booth_mult4_if;
    import booth_mult4_pkg::*;

    logic       start;
    logic [3:0] mcand;
    logic [3:0] mplier;
    logic       busy;
    logic       done;
    logic [7:0] product;

    modport master (
        output start, mcand, mplier,
        input  busy, done, product
    );

    modport slave (
        input  start, mcand, mplier,
        output busy, done, product
    );

endinterface

// File: rtl/booth_mult4_addsub.sv
// 4-bit ripple adder/subtractor (addsub4bit) built from full adders (fa).
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    // Single-bit full adder.
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end
endmodule

module addsub4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       add0sub1,
    output logic [3:0] sumdiff,
    output logic       carryborrow
);
    logic [3:0] b_x;
    logic [4:0] c;

    // Subtraction is a + ~b + 1: invert b and inject the select as carry-in.
    always_comb begin
        b_x  = b ^ {4{add0sub1}};
        c[0] = add0sub1;
    end

    for (genvar i = 0; i < 4; i++) begin : g_bit
        fa u_fa (
            .a    (a[i]),
            .b    (b_x[i]),
            .cin  (c[i]),
            .s    (sumdiff[i]),
            .cout (c[i+1])
        );
    end

    // Carry on add, borrow (inverted carry) on subtract.
    assign carryborrow = add0sub1 ? ~c[4] : c[4];
endmodule

// File: rtl/booth_mult4.sv
// Sequential 4x4 signed radix-2 Booth multiplier, one iteration per clock.
module booth_mult4
    import booth_mult4_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    booth_mult4_if.slave  bus
);

    logic [1:0] state;
    logic [3:0] acc;
    logic [3:0] q_reg;
    logic [3:0] m_reg;
    logic       q_1;
    logic [2:0] cnt;
    logic [7:0] product_r;

    booth_op_e  op;
    logic       add0sub1;
    logic [3:0] sumdiff;
    logic       carry_unused;
    logic [3:0] a_sel;
    logic       x3;
    logic       ovf;
    logic       sign;
    logic [3:0] acc_next;
    logic [3:0] q_next;

    addsub4bit u_addsub (
        .a           (acc),
        .b           (m_reg),
        .add0sub1    (add0sub1),
        .sumdiff     (sumdiff),
        .carryborrow (carry_unused)
    );

    // Booth step plus arithmetic right shift; the sign bit shifted into A is
    // corrected when the 4-bit add/sub overflowed (needed for M = -8).
    always_comb begin
        op       = booth_op(q_reg[0], q_1);
        add0sub1 = (op == OP_SUB);
        a_sel    = (op == OP_NONE) ? acc : sumdiff;
        x3       = m_reg[3] ^ add0sub1;
        ovf      = (op != OP_NONE) && (acc[3] == x3) && (sumdiff[3] != acc[3]);
        sign     = ovf ? ~a_sel[3] : a_sel[3];
        acc_next = {sign, a_sel[3:1]};
        q_next   = {a_sel[0], q_reg[3:1]};
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            acc       <= '0;
            q_reg     <= '0;
            m_reg     <= '0;
            q_1       <= 1'b0;
            cnt       <= '0;
            product_r <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        m_reg <= bus.mcand;
                        q_reg <= bus.mplier;
                        acc   <= '0;
                        q_1   <= 1'b0;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc   <= acc_next;
                    q_reg <= q_next;
                    q_1   <= q_reg[0];
                    cnt   <= cnt + 3'd1;
                    if (cnt == CNT_LAST) begin
                        product_r <= {acc_next, q_next};
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy    = (state == ST_RUN);
    assign bus.done    = (state == ST_DONE);
    assign bus.product = product_r;

endmodule
